// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor: coin codes, FSM states and the
// denomination encoder.
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_QUALIFY      = 3'd1,
    ST_ACCEPT       = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_JAM          = 3'd4
  } state_t;

  function automatic logic is_one_hot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [1:0] encode_coin(input logic [2:0] pat);
    logic [1:0] code;
    case (pat)
      3'b001:  code = COIN_1;
      3'b010:  code = COIN_2;
      3'b100:  code = COIN_3;
      default: code = COIN_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a vector of independent asynchronous inputs.
// Bits are not coherent with each other; the consumer debounces the vector.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        meta_reg[gi] <= 1'b0;
        sync_reg[gi] <= 1'b0;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises the denomination sensors, debounces
// insertions and releases, rejects invalid/inhibited coins and detects jams.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sense,
  input  logic       inhibit,
  output logic [1:0] coin_in,
  output logic       reject,
  output logic       jam
);

  localparam int CW = $clog2(JAM_CYCLES + 1);
  // Counters compare against "last sample" so the edge that takes the
  // N-th qualifying sample is the one that acts on it.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES - 1);

  logic [2:0]    s;
  state_t        state_reg;
  logic [2:0]    pat_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] rel_cnt_reg;
  logic [CW-1:0] hold_cnt_reg;
  logic          rej_pend_reg;

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sense),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_WAIT_RELEASE;
      pat_reg      <= 3'b000;
      cnt_reg      <= '0;
      rel_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      rej_pend_reg <= 1'b0;
      coin_in      <= COIN_NONE;
      reject       <= 1'b0;
      jam          <= 1'b0;
    end else begin
      coin_in <= COIN_NONE;
      reject  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (s != 3'b000) begin
            pat_reg   <= s;
            cnt_reg   <= CW'(1);
            state_reg <= ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          if (s != pat_reg) begin
            state_reg <= ST_IDLE;
          end else if (cnt_reg == DEB_LAST) begin
            // Decision edge: inhibit is only looked at here.
            rej_pend_reg <= !is_one_hot(pat_reg) || inhibit;
            state_reg    <= ST_ACCEPT;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_ACCEPT: begin
          // Shared output stage so coin and reject pulses have equal latency.
          if (rej_pend_reg) begin
            reject <= 1'b1;
          end else begin
            coin_in <= encode_coin(pat_reg);
          end
          rel_cnt_reg  <= '0;
          hold_cnt_reg <= '0;
          state_reg    <= ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          if (s == 3'b000) begin
            if (rel_cnt_reg == DEB_LAST) begin
              rel_cnt_reg  <= '0;
              hold_cnt_reg <= '0;
              state_reg    <= ST_IDLE;
            end else begin
              rel_cnt_reg <= rel_cnt_reg + CW'(1);
            end
          end else begin
            rel_cnt_reg <= '0;
            if (hold_cnt_reg == JAM_LAST) begin
              jam       <= 1'b1;
              state_reg <= ST_JAM;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + CW'(1);
            end
          end
        end
        ST_JAM: begin
          if (s == 3'b000) begin
            if (rel_cnt_reg == DEB_LAST) begin
              rel_cnt_reg  <= '0;
              hold_cnt_reg <= '0;
              jam          <= 1'b0;
              state_reg    <= ST_IDLE;
            end else begin
              rel_cnt_reg <= rel_cnt_reg + CW'(1);
            end
          end else begin
            rel_cnt_reg <= '0;
          end
        end
        default: begin
          jam       <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: insertion, glitch, reject, jam, bounce
// and reset scenarios with hand-computed edge timing.
module tb_coin_acceptor;

  logic       clk;
  logic       rst;
  logic [2:0] sense;
  logic       inhibit;
  logic [1:0] coin_in;
  logic       reject;
  logic       jam;

  int n_cmp = 0;
  int n_err = 0;

  int ecnt, coin_cnt, coin_edge, rej_cnt, rej_edge, both_cnt;
  int jam_seen, jam_edge, jam_gone, jam_drop_edge;
  logic [1:0] first_coin;

  coin_acceptor dut (
    .clk     (clk),
    .rst     (rst),
    .sense   (sense),
    .inhibit (inhibit),
    .coin_in (coin_in),
    .reject  (reject),
    .jam     (jam)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    ecnt = -1; coin_cnt = 0; coin_edge = -1; rej_cnt = 0; rej_edge = -1;
    jam_seen = 0; jam_edge = -1; jam_gone = 0; jam_drop_edge = -1;
    first_coin = 2'b00;
  endtask

  // One clock; samples outputs 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (coin_in != 2'b00) begin
      if (coin_cnt == 0) begin
        coin_edge  = ecnt;
        first_coin = coin_in;
      end
      coin_cnt++;
    end
    if (reject) begin
      if (rej_cnt == 0) rej_edge = ecnt;
      rej_cnt++;
    end
    if (reject && coin_in != 2'b00) both_cnt++;
    if (jam && jam_seen == 0) begin
      jam_seen = 1;
      jam_edge = ecnt;
    end
    if (!jam && jam_seen == 1 && jam_gone == 0) begin
      jam_gone      = 1;
      jam_drop_edge = ecnt;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold(input logic [2:0] v, input int n);
    sense = v;
    ticks(n);
  endtask

  task automatic report(input string name);
    $display("txn %s: coins=%0d code=%0d coin_edge=%0d rejects=%0d rej_edge=%0d jam_edge=%0d jam_drop=%0d",
             name, coin_cnt, first_coin, coin_edge, rej_cnt, rej_edge, jam_edge, jam_drop_edge);
  endtask

  task automatic expect_coin(input string name, input logic [2:0] v, input int code);
    clear_stats();
    hold(v, 10);
    hold(3'b000, 10);
    report(name);
    check({name, "_count"}, coin_cnt, 1);
    check({name, "_code"}, first_coin, code);
    check({name, "_edge"}, coin_edge, 6);
    check({name, "_no_reject"}, rej_cnt, 0);
  endtask

  initial begin
    both_cnt = 0;
    rst      = 1'b0;
    sense    = 3'b000;
    inhibit  = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_coin", coin_in, 0);
    check("reset_reject", reject, 0);
    check("reset_jam", jam, 0);
    rst = 1'b1;
    ticks(8);

    // Basic insertion held 20 cycles.
    clear_stats();
    hold(3'b001, 20);
    hold(3'b000, 10);
    report("coin1_long");
    check("coin1_count", coin_cnt, 1);
    check("coin1_code", first_coin, 1);
    check("coin1_edge", coin_edge, 6);
    check("coin1_no_reject", rej_cnt, 0);

    // Back in IDLE: 3-unit coin is accepted with normal latency.
    expect_coin("coin3", 3'b100, 3);

    // Three-sample glitch.
    clear_stats();
    hold(3'b100, 3);
    hold(3'b000, 10);
    report("glitch3");
    check("glitch_coin", coin_cnt, 0);
    check("glitch_reject", rej_cnt, 0);

    // Insertion broken up by a gap before qualifying.
    clear_stats();
    hold(3'b001, 3);
    hold(3'b000, 3);
    hold(3'b001, 3);
    hold(3'b000, 10);
    report("toggle");
    check("toggle_coin", coin_cnt, 0);
    check("toggle_reject", rej_cnt, 0);

    // Multi-hot pattern is rejected.
    clear_stats();
    hold(3'b011, 10);
    hold(3'b000, 10);
    report("multihot");
    check("multihot_reject", rej_cnt, 1);
    check("multihot_rej_edge", rej_edge, 6);
    check("multihot_coin", coin_cnt, 0);

    // Inhibit high at the decision edge rejects a valid coin.
    clear_stats();
    inhibit = 1'b1;
    hold(3'b010, 10);
    inhibit = 1'b0;
    hold(3'b000, 10);
    report("inhibit");
    check("inhibit_reject", rej_cnt, 1);
    check("inhibit_rej_edge", rej_edge, 6);
    check("inhibit_coin", coin_cnt, 0);

    // Inhibit that drops before the decision edge is ignored.
    clear_stats();
    inhibit = 1'b1;
    hold(3'b010, 4);
    inhibit = 1'b0;
    hold(3'b010, 6);
    hold(3'b000, 10);
    report("inhibit_early");
    check("inh_early_coin", coin_cnt, 1);
    check("inh_early_code", first_coin, 2);
    check("inh_early_reject", rej_cnt, 0);

    // Jam: sensor stuck high for 100 cycles.
    clear_stats();
    hold(3'b010, 100);
    report("jam_hold");
    check("jam_coin_once", coin_cnt, 1);
    check("jam_coin_code", first_coin, 2);
    check("jam_no_reject", rej_cnt, 0);
    check("jam_asserted", jam_seen, 1);
    check("jam_in_window", int'(jam_edge >= 64 && jam_edge <= 76), 1);
    check("jam_level", jam, 1);
    clear_stats();
    hold(3'b000, 12);
    report("jam_release");
    check("jam_drop_edge", jam_drop_edge, 5);
    check("jam_rel_coin", coin_cnt, 0);
    check("jam_rel_reject", rej_cnt, 0);
    expect_coin("after_jam", 3'b001, 1);

    // Sensor bouncing during release credits only one coin.
    clear_stats();
    hold(3'b001, 10);
    for (int i = 0; i < 5; i++) begin
      hold((i % 2 == 0) ? 3'b000 : 3'b001, 2);
    end
    hold(3'b000, 10);
    report("bounce");
    check("bounce_count", coin_cnt, 1);
    check("bounce_edge", coin_edge, 6);
    expect_coin("after_bounce", 3'b010, 2);

    // Asynchronous reset while coin_in is high, coin held across reset.
    clear_stats();
    hold(3'b001, 7);
    check("pre_reset_coin", coin_in, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_coin", coin_in, 0);
    check("async_rst_reject", reject, 0);
    check("async_rst_jam", jam, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_stats();
    hold(3'b001, 20);
    report("held_across_reset");
    check("held_rst_coin", coin_cnt, 0);
    check("held_rst_reject", rej_cnt, 0);
    hold(3'b000, 10);
    expect_coin("after_reset", 3'b001, 1);

    check("no_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
